// File: rtl/tow_round_ctrl.sv
// Tug-of-war match sequencer: press edge detection/arbitration, round FSM, scores, match winner.
// Define TOW_FALSE_START_EN to treat edges during the countdown as false starts.
module tow_round_ctrl #(
    parameter int unsigned FIELD_W   = 9,
    parameter int unsigned SCORE_MAX = 7,
    parameter int unsigned START_DLY = 4,
    parameter int unsigned HOLD_DLY  = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       new_game,
    input  logic                       press_l,
    input  logic                       press_r,
    output logic [$clog2(FIELD_W)-1:0] pos,
    output logic [FIELD_W-1:0]         led,
    output logic [2:0]                 score_l,
    output logic [2:0]                 score_r,
    output logic                       round_win_l,
    output logic                       round_win_r,
    output logic                       match_over,
    output logic                       winner,
    output logic [2:0]                 state
);

    localparam int unsigned POS_W   = $clog2(FIELD_W);
    localparam int unsigned CENTER  = (FIELD_W - 1) / 2;
    localparam int unsigned DLY_MAX = (START_DLY > HOLD_DLY) ? START_DLY : HOLD_DLY;
    localparam int unsigned CNT_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;

    localparam logic [POS_W-1:0]   POS_CENTER = POS_W'(CENTER);
    localparam logic [POS_W-1:0]   POS_LAST   = POS_W'(FIELD_W - 1);
    localparam logic [FIELD_W-1:0] LED_CENTER = FIELD_W'(1) << CENTER;
    localparam logic [CNT_W-1:0]   START_LD   = CNT_W'(START_DLY - 1);
    localparam logic [CNT_W-1:0]   HOLD_LD    = CNT_W'(HOLD_DLY - 1);
    localparam logic [2:0]         SCORE_TOP  = 3'(SCORE_MAX);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAY      = 3'd2,
        ST_POINT     = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [FIELD_W-1:0] led_q, led_d;
    logic [2:0]         score_l_q, score_l_d, score_r_q, score_r_d;
    logic               win_l_q, win_l_d, win_r_q, win_r_d;
    logic               winner_q, winner_d, over_q, over_d;
    logic               pl_q, pr_q;
    logic               el, er, lone_l, lone_r, award_l, award_r;

    assign el     = press_l & ~pl_q;
    assign er     = press_r & ~pr_q;
    assign lone_l = el & ~er;
    assign lone_r = er & ~el;

    // Next-state, rope movement and round/match award logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pos_d     = pos_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        win_l_d   = 1'b0;
        win_r_d   = 1'b0;
        winner_d  = winner_q;
        over_d    = over_q;
        award_l   = 1'b0;
        award_r   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pos_d = POS_CENTER;
                if (el | er) begin
                    state_d = ST_COUNTDOWN;
                    cnt_d   = START_LD;
                end
            end
            ST_COUNTDOWN: begin
                pos_d = POS_CENTER;
`ifdef TOW_FALSE_START_EN
                if (el & er) begin
                    cnt_d = START_LD;
                end else if (lone_l) begin
                    award_r = 1'b1;
                end else if (lone_r) begin
                    award_l = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = ST_PLAY;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`else
                if (cnt_q == '0) begin
                    state_d = ST_PLAY;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`endif
            end
            ST_PLAY: begin
                if (lone_l) begin
                    if (pos_q < POS_LAST) pos_d = pos_q + POS_W'(1);
                    else                  award_l = 1'b1;
                end else if (lone_r) begin
                    if (pos_q > '0) pos_d = pos_q - POS_W'(1);
                    else            award_r = 1'b1;
                end
            end
            ST_POINT: begin
                if (cnt_q == '0) begin
                    state_d = ST_COUNTDOWN;
                    cnt_d   = START_LD;
                    pos_d   = POS_CENTER;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: over_d = 1'b1;
            default: state_d = ST_IDLE;
        endcase

        // Shared round-win path for PLAY wins and false-start awards.
        if (award_l) begin
            score_l_d = (score_l_q < SCORE_TOP) ? score_l_q + 3'd1 : score_l_q;
            win_l_d   = 1'b1;
            if (score_l_d == SCORE_TOP) begin
                state_d  = ST_DONE;
                winner_d = 1'b0;
                over_d   = 1'b1;
            end else begin
                state_d = ST_POINT;
                cnt_d   = HOLD_LD;
            end
        end else if (award_r) begin
            score_r_d = (score_r_q < SCORE_TOP) ? score_r_q + 3'd1 : score_r_q;
            win_r_d   = 1'b1;
            if (score_r_d == SCORE_TOP) begin
                state_d  = ST_DONE;
                winner_d = 1'b1;
                over_d   = 1'b1;
            end else begin
                state_d = ST_POINT;
                cnt_d   = HOLD_LD;
            end
        end

        if (new_game) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            pos_d     = POS_CENTER;
            score_l_d = 3'd0;
            score_r_d = 3'd0;
            win_l_d   = 1'b0;
            win_r_d   = 1'b0;
            winner_d  = 1'b0;
            over_d    = 1'b0;
        end

        led_d = FIELD_W'(1) << pos_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pos_q     <= POS_CENTER;
            led_q     <= LED_CENTER;
            score_l_q <= 3'd0;
            score_r_q <= 3'd0;
            win_l_q   <= 1'b0;
            win_r_q   <= 1'b0;
            winner_q  <= 1'b0;
            over_q    <= 1'b0;
            pl_q      <= 1'b0;
            pr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pos_q     <= pos_d;
            led_q     <= led_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            win_l_q   <= win_l_d;
            win_r_q   <= win_r_d;
            winner_q  <= winner_d;
            over_q    <= over_d;
            pl_q      <= press_l;
            pr_q      <= press_r;
        end
    end

    assign pos         = pos_q;
    assign led         = led_q;
    assign score_l     = score_l_q;
    assign score_r     = score_r_q;
    assign round_win_l = win_l_q;
    assign round_win_r = win_r_q;
    assign match_over  = over_q;
    assign winner      = winner_q;
    assign state       = state_q;

endmodule

// File: tb/tb_tow_round_ctrl.sv
// Self-checking bench for tow_round_ctrl at default parameters (field 9, 7 wins, countdown 4, hold 8).
module tb_tow_round_ctrl;

    logic       clk = 1'b0;
    logic       reset_n, new_game, press_l, press_r;
    logic [3:0] pos;
    logic [8:0] led;
    logic [2:0] score_l, score_r, state;
    logic       round_win_l, round_win_r, match_over, winner;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_score_l = 0;

    typedef struct {
        logic [3:0] pos;
        logic [2:0] score;
        logic       win;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    tow_round_ctrl dut (
        .clk(clk), .reset_n(reset_n), .new_game(new_game),
        .press_l(press_l), .press_r(press_r),
        .pos(pos), .led(led), .score_l(score_l), .score_r(score_r),
        .round_win_l(round_win_l), .round_win_r(round_win_r),
        .match_over(match_over), .winner(winner), .state(state)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; new_game = 1'b0; press_l = 1'b0; press_r = 1'b0;
        #12;
        n_tests++;
        if ({state, pos, led, score_l, score_r, round_win_l, round_win_r, match_over, winner}
            !== {3'd0, 4'd4, 9'b000010000, 3'd0, 3'd0, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_values: state=%0d pos=%0d led=%b sl=%0d sr=%0d wl=%b wr=%b mo=%b w=%b, want 0 4 000010000 0 0 0 0 0 0",
                     state, pos, led, score_l, score_r, round_win_l, round_win_r, match_over, winner);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_countdown();
        int n;
        int n_exp;
        press_l = 1'b1;
        tick();
        n_tests++;
        if ({state, pos} !== {3'd1, 4'd4}) begin
            n_fail++;
            $display("FAIL countdown_entry: state=%0d pos=%0d, want 1 4", state, pos);
        end
        press_l = 1'b0;
        press_r = 1'b1;
        tick();
        n_tests++;
`ifdef TOW_FALSE_START_EN
        exp_score_l = 1;
        n_exp = 12;
        if ({state, round_win_l, score_l} !== {3'd3, 1'b1, 3'd1}) begin
            n_fail++;
            $display("FAIL false_start: state=%0d wl=%b sl=%0d, want 3 1 1", state, round_win_l, score_l);
        end
`else
        n_exp = 3;
        if ({state, round_win_l, score_l} !== {3'd1, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL countdown_ignore: state=%0d wl=%b sl=%0d, want 1 0 0", state, round_win_l, score_l);
        end
`endif
        press_r = 1'b0;
        n = 0;
        while (state !== 3'd2 && n < 40) begin
            tick();
            n++;
        end
        n_tests++;
        if (n !== n_exp || pos !== 4'd4) begin
            n_fail++;
            $display("FAIL countdown_len: reached PLAY after %0d cycles pos=%0d, want %0d cycles pos 4", n, pos, n_exp);
        end
    endtask

    task automatic test_play_left();
        exp_t e;
        logic bad;
        for (int i = 1; i <= 5; i++) begin
            press_l = 1'b1;
            if (i < 5) begin
                sb.push_back('{pos: 4'(4 + i), score: 3'(exp_score_l), win: 1'b0});
            end else begin
                exp_score_l++;
                sb.push_back('{pos: 4'd8, score: 3'(exp_score_l), win: 1'b1});
            end
            tick();
            e = sb.pop_front();
            n_tests++;
            if ({pos, score_l, round_win_l} !== {e.pos, e.score, e.win} || led !== (9'd1 << e.pos)) begin
                n_fail++;
                $display("FAIL left_step%0d: pos=%0d led=%b sl=%0d wl=%b, want pos=%0d sl=%0d wl=%b",
                         i, pos, led, score_l, round_win_l, e.pos, e.score, e.win);
            end
            press_l = 1'b0;
            tick();
        end
        n_tests++;
        if ({round_win_l, state} !== {1'b0, 3'd3}) begin
            n_fail++;
            $display("FAIL left_pulse_width: wl=%b state=%0d, want 0 3", round_win_l, state);
        end
        bad = 1'b0;
        repeat (6) begin
            tick();
            if (state !== 3'd3) bad = 1'b1;
        end
        tick();
        n_tests++;
        if ({bad, state, pos} !== {1'b0, 3'd1, 4'd4}) begin
            n_fail++;
            $display("FAIL point_hold: early_exit=%b state=%0d pos=%0d, want 0 1 4", bad, state, pos);
        end
        repeat (3) tick();
        n_tests++;
        if (state !== 3'd1) begin
            n_fail++;
            $display("FAIL countdown_hold: state=%0d, want 1", state);
        end
        tick();
        n_tests++;
        if (state !== 3'd2) begin
            n_fail++;
            $display("FAIL countdown_to_play: state=%0d, want 2", state);
        end
    endtask

    task automatic test_hold_and_tie();
        press_l = 1'b1;
        tick();
        n_tests++;
        if (pos !== 4'd5) begin
            n_fail++;
            $display("FAIL hold_first: pos=%0d, want 5", pos);
        end
        repeat (9) tick();
        n_tests++;
        if ({pos, state} !== {4'd5, 3'd2}) begin
            n_fail++;
            $display("FAIL hold_single_step: pos=%0d state=%0d, want 5 2", pos, state);
        end
        press_l = 1'b0;
        tick();
        press_l = 1'b1;
        press_r = 1'b1;
        tick();
        n_tests++;
        if (pos !== 4'd5) begin
            n_fail++;
            $display("FAIL tie_cancel: pos=%0d, want 5", pos);
        end
        press_l = 1'b0;
        press_r = 1'b0;
        tick();
        press_r = 1'b1;
        tick();
        n_tests++;
        if (pos !== 4'd4) begin
            n_fail++;
            $display("FAIL right_step: pos=%0d, want 4", pos);
        end
        press_r = 1'b0;
        tick();
    endtask

    task automatic test_match_right();
        exp_t e;
        int n;
        for (int k = 1; k <= 7; k++) begin
            for (int i = 1; i <= 5; i++) begin
                press_r = 1'b1;
                if (i < 5) sb.push_back('{pos: 4'(4 - i), score: 3'(k - 1), win: 1'b0});
                else       sb.push_back('{pos: 4'd0, score: 3'(k), win: 1'b1});
                tick();
                e = sb.pop_front();
                n_tests++;
                if ({pos, score_r, round_win_r} !== {e.pos, e.score, e.win}) begin
                    n_fail++;
                    $display("FAIL right_round%0d_step%0d: pos=%0d sr=%0d wr=%b, want pos=%0d sr=%0d wr=%b",
                             k, i, pos, score_r, round_win_r, e.pos, e.score, e.win);
                end
                press_r = 1'b0;
                tick();
            end
            if (k < 7) begin
                n = 0;
                while (state !== 3'd2 && n < 40) begin
                    tick();
                    n++;
                end
                n_tests++;
                if (n !== 11) begin
                    n_fail++;
                    $display("FAIL round%0d_restart: PLAY after %0d cycles, want 11", k, n);
                end
            end else begin
                n_tests++;
                if ({state, match_over, winner, score_r} !== {3'd4, 1'b1, 1'b1, 3'd7}) begin
                    n_fail++;
                    $display("FAIL match_done: state=%0d mo=%b w=%b sr=%0d, want 4 1 1 7",
                             state, match_over, winner, score_r);
                end
            end
        end
        press_l = 1'b1; tick(); press_l = 1'b0; tick();
        press_r = 1'b1; tick(); press_r = 1'b0; tick();
        n_tests++;
        if ({state, score_l, score_r, pos, match_over} !== {3'd4, 3'(exp_score_l), 3'd7, 4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL done_frozen: state=%0d sl=%0d sr=%0d pos=%0d mo=%b, want 4 %0d 7 0 1",
                     state, score_l, score_r, pos, match_over, exp_score_l);
        end
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        n_tests++;
        if ({state, score_l, score_r, pos, led, match_over, winner}
            !== {3'd0, 3'd0, 3'd0, 4'd4, 9'b000010000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL new_game: state=%0d sl=%0d sr=%0d pos=%0d led=%b mo=%b w=%b, want 0 0 0 4 000010000 0 0",
                     state, score_l, score_r, pos, led, match_over, winner);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        press_l = 1'b1; tick(); press_l = 1'b0;
        n = 0;
        while (state !== 3'd2 && n < 40) begin
            tick();
            n++;
        end
        repeat (3) begin
            press_l = 1'b1; tick(); press_l = 1'b0; tick();
        end
        n_tests++;
        if ({state, pos} !== {3'd2, 4'd7}) begin
            n_fail++;
            $display("FAIL mid_setup: state=%0d pos=%0d, want 2 7", state, pos);
        end
        #2;
        reset_n = 1'b0;
        press_l = 1'b1;
        #1;
        n_tests++;
        if ({state, pos, led, score_l, score_r, round_win_l, round_win_r, match_over, winner}
            !== {3'd0, 4'd4, 9'b000010000, 3'd0, 3'd0, 4'b0000}) begin
            n_fail++;
            $display("FAIL async_reset: state=%0d pos=%0d led=%b sl=%0d sr=%0d, want 0 4 000010000 0 0",
                     state, pos, led, score_l, score_r);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        n_tests++;
        if (state !== 3'd1) begin
            n_fail++;
            $display("FAIL held_through_reset: state=%0d, want 1", state);
        end
        press_l = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_play_left();
        test_hold_and_tie();
        test_match_right();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
